// File: rtl/led_matrix_scanner.sv
// Double-buffered row-scan LED matrix driver with inter-row blanking and PWM brightness.
// Latency: all outputs registered; scan state of cycle k is on the pins in cycle k+1.
// Backpressure: none; writes are accepted every cycle, and a swap request waits for the frame boundary.
//
// Ports:
//   clk, reset         - system clock, synchronous active-high reset
//   wr_en/wr_row/wr_data - write a row pattern into the back buffer (out-of-range rows dropped)
//   swap_req           - request a front/back exchange at the next frame boundary
//   brightness         - PWM duty 0..15, latched at the start of each frame
//   swap_pending       - a swap has been requested but not yet performed
//   row, col           - one-hot row select, column drive (optionally inverted)
//   frame_start        - one-cycle pulse on the first clock of row 0's slot
module led_matrix_scanner #(
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int TICKS_PER_ROW  = 1000,
  parameter int BLANK          = 4,
  parameter int ACTIVE_LOW_COL = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [$clog2(ROWS)-1:0]   wr_row,
  input  logic [COLS-1:0]           wr_data,
  input  logic                      swap_req,
  input  logic [3:0]                brightness,
  output logic                      swap_pending,
  output logic [ROWS-1:0]           row,
  output logic [COLS-1:0]           col,
  output logic                      frame_start
);

  localparam int RW = $clog2(ROWS);
  localparam int TW = $clog2(TICKS_PER_ROW);
  // Column level that turns every LED in the row off.
  localparam logic [COLS-1:0] COL_OFF = (ACTIVE_LOW_COL != 0) ? '1 : '0;

  logic [TW-1:0]   tick;
  logic [RW-1:0]   row_idx;
  logic            bank_sel;   // bank currently displayed (front)
  logic [3:0]      bright_q;

  logic [COLS-1:0] bank0 [ROWS];
  logic [COLS-1:0] bank1 [ROWS];

  logic            tick_last;
  logic            row_last;
  logic            frame_first;
  logic            frame_end;
  logic            blanking;
  logic [3:0]      pwm;
  logic            lit;
  logic            wr_ok;
  logic [COLS-1:0] front_row;
  logic [ROWS-1:0] row_nxt;
  logic [COLS-1:0] col_nxt;

  always_comb begin
    tick_last   = (tick == TW'(TICKS_PER_ROW - 1));
    row_last    = (row_idx == RW'(ROWS - 1));
    frame_first = (tick == '0) && (row_idx == '0);
    frame_end   = tick_last && row_last;
    blanking    = (tick < TW'(BLANK));
    // PWM phase restarts at the end of blanking so every row gets the same duty pattern.
    pwm         = 4'(tick - TW'(BLANK));
    lit         = (bright_q == 4'd15) || (pwm < bright_q);
    wr_ok       = (int'(wr_row) < ROWS);
    front_row   = bank_sel ? bank1[row_idx] : bank0[row_idx];

    row_nxt = '0;
    col_nxt = COL_OFF;
    if (!blanking) begin
      row_nxt = {{(ROWS-1){1'b0}}, 1'b1} << row_idx;
      col_nxt = (lit ? front_row : '0) ^ COL_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick         <= '0;
      row_idx      <= '0;
      bank_sel     <= 1'b0;
      bright_q     <= 4'd0;
      swap_pending <= 1'b0;
      row          <= '0;
      col          <= COL_OFF;
      frame_start  <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else begin
      row         <= row_nxt;
      col         <= col_nxt;
      frame_start <= frame_first;

      if (tick_last) begin
        tick    <= '0;
        row_idx <= row_last ? '0 : row_idx + 1'b1;
      end else begin
        tick <= tick + 1'b1;
      end

      if (frame_first) begin
        bright_q <= brightness;
      end

      // Writes always land in the bank that is not displayed at this moment, so a
      // write on the boundary cycle ends up in the frame that follows the swap.
      if (wr_en && wr_ok) begin
        if (bank_sel) bank0[wr_row] <= wr_data;
        else          bank1[wr_row] <= wr_data;
      end

      // A request arriving on the boundary itself only arms the next boundary.
      if (frame_end && swap_pending) begin
        bank_sel     <= ~bank_sel;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
module tb_led_matrix_scanner;

  localparam int R  = 8;
  localparam int T  = 40;
  localparam int BL = 4;
  localparam int F  = R * T;
  localparam int F6 = 6 * T;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en, swap_req;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic [3:0] brightness;
  logic       swap_pending, frame_start;
  logic [7:0] row, col;

  logic       w6_en, s6_req;
  logic [2:0] w6_row;
  logic [7:0] w6_data;
  logic       sp6, fs6;
  logic [5:0] row6;
  logic [7:0] col6;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  led_matrix_scanner #(.ROWS(8), .COLS(8), .TICKS_PER_ROW(T), .BLANK(BL), .ACTIVE_LOW_COL(1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .swap_req(swap_req), .brightness(brightness), .swap_pending(swap_pending),
    .row(row), .col(col), .frame_start(frame_start));

  led_matrix_scanner #(.ROWS(6), .COLS(8), .TICKS_PER_ROW(T), .BLANK(BL), .ACTIVE_LOW_COL(1)) dut6 (
    .clk(clk), .reset(reset), .wr_en(w6_en), .wr_row(w6_row), .wr_data(w6_data),
    .swap_req(s6_req), .brightness(brightness), .swap_pending(sp6),
    .row(row6), .col(col6), .frame_start(fs6));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (8-row instance) ----------------
  // Scan position is pure arithmetic on the number of clocks since reset;
  // buffers are two whole pattern arrays exchanged on a swap.
  logic [7:0] m_front [R];
  logic [7:0] m_back  [R];
  logic [3:0] m_bq;
  logic       m_pend, m_run = 1'b0;
  int         m_cnt;
  logic [7:0] e_row, e_col;
  logic       e_pend, e_fs;

  always @(posedge clk) begin
    if (reset) begin
      m_run = 1'b1; m_cnt = 0; m_pend = 1'b0; m_bq = 4'd0;
      for (int i = 0; i < R; i++) begin m_front[i] = 8'h00; m_back[i] = 8'h00; end
      e_row = 8'h00; e_col = 8'hFF; e_pend = 1'b0; e_fs = 1'b0;
    end else if (m_run) begin
      int tk, ri, pw;
      logic [7:0] tmp;
      tk = m_cnt % T;
      ri = (m_cnt / T) % R;
      e_fs = ((m_cnt % F) == 0);
      if (tk < BL) begin
        e_row = 8'h00; e_col = 8'hFF;
      end else begin
        pw = (tk - BL) % 16;
        e_row = 8'(1 << ri);
        e_col = ((m_bq == 4'd15) || (pw < int'(m_bq))) ? ~m_front[ri] : 8'hFF;
      end
      if ((m_cnt % F) == 0) m_bq = brightness;
      if (wr_en && int'(wr_row) < R) m_back[wr_row] = wr_data;
      if ((m_cnt % F) == F - 1 && m_pend) begin
        for (int i = 0; i < R; i++) begin
          tmp = m_front[i]; m_front[i] = m_back[i]; m_back[i] = tmp;
        end
        m_pend = 1'b0;
      end else if (swap_req) begin
        m_pend = 1'b1;
      end
      e_pend = m_pend;
      m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (m_run) begin
      chk("model row", 32'(row), 32'(e_row));
      chk("model col", 32'(col), 32'(e_col));
      chk("model swap_pending", 32'(swap_pending), 32'(e_pend));
      chk("model frame_start", 32'(frame_start), 32'(e_fs));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic write_row(input logic [2:0] r, input logic [7:0] d);
    wr_en = 1'b1; wr_row = r; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
  endtask

  task automatic wait_swap_done(input string nm);
    int n = 0;
    while (swap_pending && n < 3 * F) begin @(negedge clk); n++; end
    chk(nm, 32'(swap_pending), 32'd0);
  endtask

  // Counts, over n cycles starting at the current one: cycles showing row 2 with
  // pattern pat, blanking cycles, and cycles with any column driven.
  task automatic count_n(input int n, input logic [7:0] pat,
                         output int lit, output int blank, output int on);
    lit = 0; blank = 0; on = 0;
    for (int i = 0; i < n; i++) begin
      if (row == 8'h04 && col == ~pat) lit++;
      if (row == 8'h00 && col == 8'hFF) blank++;
      if (col != 8'hFF) on++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [3:0] bright;
    logic [7:0] pat;
    int         lit_cycles;   // active cycles of row 2 showing the pattern
  } vec_t;

  vec_t vecs [6];

  initial begin
    int lit, blank, on, n;
    // 36 active cycles per row: PWM phases 0..15, 0..15, 0..3
    vecs[0] = '{4'd15, 8'hA5, 36};
    vecs[1] = '{4'd4,  8'h3C, 12};
    vecs[2] = '{4'd0,  8'hFF, 0};
    vecs[3] = '{4'd1,  8'h81, 3};
    vecs[4] = '{4'd7,  8'h5A, 18};
    vecs[5] = '{4'd12, 8'h0F, 28};

    reset = 1'b1; wr_en = 1'b0; wr_row = 3'd0; wr_data = 8'h00; swap_req = 1'b0;
    brightness = 4'd0; w6_en = 1'b0; w6_row = 3'd0; w6_data = 8'h00; s6_req = 1'b0;

    // Reset hold and frame_start cadence
    repeat (3) @(negedge clk);
    chk("reset row", 32'(row), 32'h00);
    chk("reset col", 32'(col), 32'hFF);
    chk("reset swap_pending", 32'(swap_pending), 32'd0);
    chk("reset frame_start", 32'(frame_start), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("first frame_start", 32'(frame_start), 32'd1);
    repeat (F) @(negedge clk);
    chk("second frame_start", 32'(frame_start), 32'd1);

    // Table: brightness x pattern -> lit cycles in row 2 of the frame after the swap
    for (int v = 0; v < 6; v++) begin
      brightness = vecs[v].bright;
      write_row(3'd2, vecs[v].pat);
      pulse_swap();
      chk($sformatf("vec%0d swap_pending set", v), 32'(swap_pending), 32'd1);
      wait_swap_done($sformatf("vec%0d swap done", v));
      @(negedge clk);
      chk($sformatf("vec%0d frame_start", v), 32'(frame_start), 32'd1);
      count_n(F, vecs[v].pat, lit, blank, on);
      chk($sformatf("vec%0d lit cycles", v), 32'(lit), 32'(vecs[v].lit_cycles));
      chk($sformatf("vec%0d blank cycles", v), 32'(blank), 32'(R * BL));
    end

    // Mid-frame brightness change waits for the next frame
    brightness = 4'd15;
    write_row(3'd2, 8'hA5);
    pulse_swap();
    wait_swap_done("midframe swap done");
    @(negedge clk);
    repeat (10) @(negedge clk);
    brightness = 4'd0;
    count_n(F - 10, 8'hA5, lit, blank, on);
    chk("midframe same-frame lit", 32'(lit), 32'd36);
    count_n(F, 8'hA5, lit, blank, on);
    chk("midframe next-frame dark", 32'(on), 32'd0);

    // swap_req on the boundary cycle defers the swap by one frame
    brightness = 4'd15;
    write_row(3'd5, 8'h0F);
    n = 0;
    while (!frame_start && n < F + 4) begin @(negedge clk); n++; end
    chk("boundary frame_start seen", 32'(frame_start), 32'd1);
    repeat (F - 2) @(negedge clk);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    n = 0;
    while (swap_pending && n < 3 * F) begin n++; @(negedge clk); end
    chk("boundary pending cycles", 32'(n), 32'(F));

    // 6-row instance: out-of-range write ignored
    w6_en = 1'b1; w6_row = 3'd1; w6_data = 8'h3C; @(negedge clk);
    w6_row = 3'd7; w6_data = 8'hFF; @(negedge clk);
    w6_en = 1'b0;
    s6_req = 1'b1; @(negedge clk); s6_req = 1'b0;
    n = 0;
    while (sp6 && n < 3 * F6) begin @(negedge clk); n++; end
    chk("rows6 swap done", 32'(sp6), 32'd0);
    @(negedge clk);
    chk("rows6 frame_start", 32'(fs6), 32'd1);
    begin
      int good, bad;
      good = 0; bad = 0;
      for (int i = 0; i < F6; i++) begin
        if (col6 != 8'hFF) begin
          if (row6 == 6'b000010 && col6 == 8'hC3) good++;
          else bad++;
        end
        @(negedge clk);
      end
      chk("rows6 row1 lit cycles", 32'(good), 32'd36);
      chk("rows6 stray drive cycles", 32'(bad), 32'd0);
    end

    // Reset mid-frame with a swap pending
    write_row(3'd3, 8'h81);
    pulse_swap();
    wait_swap_done("resetmid swap done");
    pulse_swap();
    n = 0;
    while (row != 8'h08 && n < 2 * F) begin @(negedge clk); n++; end
    chk("resetmid row3 reached", 32'(row), 32'h08);
    chk("resetmid pending before", 32'(swap_pending), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("resetmid row", 32'(row), 32'h00);
    chk("resetmid col", 32'(col), 32'hFF);
    chk("resetmid swap_pending", 32'(swap_pending), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("resetmid frame_start", 32'(frame_start), 32'd1);
    count_n(F, 8'h00, lit, blank, on);
    chk("resetmid cleared display", 32'(on), 32'd0);

    // Randomised traffic checked by the reference model
    for (int i = 0; i < 3000; i++) begin
      wr_en    = ($urandom_range(3) == 0);
      wr_row   = 3'($urandom);
      wr_data  = 8'($urandom);
      swap_req = ($urandom_range(63) == 0);
      if ($urandom_range(99) == 0) brightness = 4'($urandom);
      reset    = ($urandom_range(799) == 0);
      @(negedge clk);
    end
    reset = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
- Parametrised, double-buffered row-scan driver for the LED matrix on the CPU's col/row pins.
- Replaces direct CPU driving of col/row: the CPU writes row patterns into a back buffer and requests a swap.
- The block refreshes the front buffer continuously, with inter-row blanking and PWM brightness.
- It sits between the cpu core and the top-level matrix pins.

Parameters:
ROWS, 8, number of matrix rows (2..16)
COLS, 8, number of columns (bits per row pattern)
TICKS_PER_ROW, 1000, clocks each row slot lasts, including blanking (must be >= BLANK+16)
BLANK, 4, clocks of dead time at the start of each row slot
ACTIVE_LOW_COL, 1, 1 means col pins are inverted (lit LED = 0)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  write strobe into the back buffer
wr_row  in  $clog2(ROWS)  row index to write
wr_data  in  COLS  row pattern; bit i = column i lit
swap_req  in  1  single-cycle request to swap buffers at the next frame boundary
brightness  in  4  duty level 0..15
swap_pending  out  1  swap requested, not yet performed
row  out  ROWS  one-hot active-high row select
col  out  COLS  column drive, polarity per ACTIVE_LOW_COL
frame_start  out  1  one-cycle pulse at the first clock of row 0's slot

Behaviour:
- Clock and reset: single clock domain. `reset` is synchronous, active-high, and is sampled on the rising edge of clk.
- Reset values:
  - row=0; col=all-off (all 1s if ACTIVE_LOW_COL, else 0); swap_pending=0; frame_start=0.
  - Both buffers are cleared to 0; front bank select is 0.
  - tick=0, row_idx=0; latched brightness is 0.
- Scan counters:
  - tick counts 0..TICKS_PER_ROW-1 and then wraps to 0.
  - row_idx increments on tick wrap; it wraps from ROWS-1 to 0. That wrap is the frame boundary.
- Output timing:
  - All outputs are registered: counter state in cycle k appears on the pins in cycle k+1.
  - The first cycle after reset deassertion drives frame_start=1 with row 0 blanking.
- Blanking: for tick < BLANK, row=0 and col=all-off.
- Active window (tick >= BLANK):
  - row = one-hot(row_idx).
  - col = front[row_idx] if lit, else all-off. Inversion is applied when ACTIVE_LOW_COL=1.
- PWM:
  - pwm = (tick-BLANK) mod 16.
  - lit = (bright_q==15) || (pwm < bright_q).
  - bright_q=0 means never lit; bright_q=15 means always lit.
- Brightness latch: bright_q samples `brightness` only at tick=0 of row 0. A mid-frame change takes effect next frame.
- Writes:
  - wr_en writes wr_data into back[wr_row].
  - wr_row >= ROWS is ignored with no side effect.
  - Writes never touch the displayed front buffer.
- Swap handshake:
  - swap_req sets swap_pending on the next cycle. swap_req while already pending has no further effect.
  - At the frame boundary cycle with swap_pending=1: front select toggles and swap_pending clears. frame_start of the new frame displays the new front.
  - swap_req in the same cycle as the boundary is too late: it only sets swap_pending, and the swap occurs at the following boundary.
  - A write in the boundary cycle targets the pre-swap back bank, so its data appears in the new front frame.
  - After a swap, the new back holds the old front contents. No copy or clear is performed.
- Reset mid-operation: abandons the current frame and any pending swap. Outputs return to reset values on the next cycle.

Test Plan:
(Use ROWS=8, COLS=8, TICKS_PER_ROW=40, BLANK=4, ACTIVE_LOW_COL=1 unless stated otherwise.)
1. Reset:
   - Hold reset 3 cycles -> row=8'h00, col=8'hFF, swap_pending=0.
   - Release -> frame_start=1 on the first cycle after release, then again every 320 cycles.
2. Write and swap:
   - Write row 2=8'hA5, brightness=15, pulse swap_req -> swap_pending=1 until the frame boundary, then 0.
   - In the next frame, in row 2's active window: row=8'h04, col=8'h5A for 36 consecutive cycles.
3. Blanking: at every row change, row=0 and col=8'hFF for exactly 4 cycles, then row advances by one-hot shift. Row 7 is followed by row 0.
4. Brightness:
   - brightness=4 -> in each 16-cycle PWM period, col shows the pattern for exactly 4 cycles.
   - brightness=0 -> col stays 8'hFF.
   - Change brightness mid-frame -> no effect until the next frame_start.
5. Boundary handshake:
   - swap_req asserted exactly on the frame-boundary cycle -> the swap occurs one frame later.
   - With ROWS=6, wr_row=7 write -> ignored, no displayed change.
6. Reset mid-frame:
   - Assert reset during row 3 with swap_pending=1 -> next cycle row=0, col=8'hFF, swap_pending=0.
   - After release, all rows display 8'h00.
